// File: rtl/data_memory_block_ctrl.sv
// data_memory_block_ctrl
//   Block-organised data memory that sits below the data cache on the miss
//   path. Each request serves one block read or one byte-enabled block write.
//   The access takes a fixed, programmable number of cycles, during which
//   BUSYWAIT is held high. Illegal requests are rejected with a one-cycle
//   ERROR pulse.
//
// Ports
//   CLOCK      in   system clock; all state changes on the rising edge
//   RESET      in   asynchronous active-low reset (clears memory and state)
//   READ       in   block read request
//   WRITE      in   block write request
//   ADDRESS    in   block address (byte address bits above the block offset)
//   WRITEDATA  in   write block; byte k is bits [8k+7:8k]
//   BYTE_EN    in   per-byte write enable, ignored on reads
//   READDATA   out  registered read block
//   BUSYWAIT   out  access in progress; requester holds its inputs while high
//   ERROR      out  one-cycle pulse when a request is rejected
module data_memory_block_ctrl #(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned BLOCK_BYTES  = 16,
  parameter int unsigned DEPTH_BLOCKS = 16,
  parameter int unsigned LATENCY      = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        ADDRESS,
  input  logic [8*BLOCK_BYTES-1:0] WRITEDATA,
  input  logic [BLOCK_BYTES-1:0]   BYTE_EN,
  output logic [8*BLOCK_BYTES-1:0] READDATA,
  output logic                     BUSYWAIT,
  output logic                     ERROR
);

  localparam int unsigned DATA_W = 8 * BLOCK_BYTES;
  localparam int unsigned IDX_W  = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // One extra bit so DEPTH_BLOCKS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH_BLOCKS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_write_q, op_write_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BLOCK_BYTES-1:0] be_q, be_d;
  logic [DATA_W-1:0]    readdata_q, readdata_d;
  logic                 error_q, error_d;
  logic [DATA_W-1:0]    mem_q [DEPTH_BLOCKS];
  logic [DATA_W-1:0]    mem_d [DEPTH_BLOCKS];

  // Request qualification
  logic req_any;
  logic req_valid;
  logic req_reject;
  logic addr_ok;

  always_comb begin
    addr_ok    = ({1'b0, ADDRESS} < DEPTH_LIMIT);
    req_any    = READ | WRITE;
    req_valid  = (READ ^ WRITE) & addr_ok;
    req_reject = req_any & ~req_valid;
  end

  // Access strobe and operand selection. With LATENCY == 1 the access is
  // performed on the accepting edge, so operands come straight from the
  // inputs; otherwise the latched copies are used.
  logic                   do_access;
  logic                   acc_write;
  logic [IDX_W-1:0]       acc_idx;
  logic [DATA_W-1:0]      acc_wdata;
  logic [BLOCK_BYTES-1:0] acc_be;

  always_comb begin
    do_access = 1'b0;
    acc_write = op_write_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      do_access = req_valid && (LATENCY == 1);
      acc_write = WRITE;
      acc_idx   = ADDRESS[IDX_W-1:0];
      acc_wdata = WRITEDATA;
      acc_be    = BYTE_EN;
    end else if (state_q == S_ACCESS) begin
      do_access = (cnt_q == CNT_ONE);
    end
  end

  // FSM: state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (LATENCY == 1) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. BUSYWAIT is gated by reset so it drops immediately when an
  // access is aborted, even if the requester still holds its request.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (RESET) begin
      case (state_q)
        S_IDLE:   BUSYWAIT = req_valid;
        S_ACCESS: BUSYWAIT = 1'b1;
        default:  BUSYWAIT = 1'b0;
      endcase
    end
  end

  assign READDATA = readdata_q;
  assign ERROR    = error_q;

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    readdata_d = readdata_q;
    error_d    = 1'b0;
    mem_d      = mem_q;

    if (state_q == S_IDLE) begin
      error_d = req_reject;
      if (req_valid) begin
        cnt_d      = CNT_LOAD;
        op_write_d = WRITE;
        idx_d      = ADDRESS[IDX_W-1:0];
        wdata_d    = WRITEDATA;
        be_d       = BYTE_EN;
      end
    end else if (state_q == S_ACCESS) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (do_access) begin
      if (acc_write) begin
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
          if (acc_be[k]) begin
            mem_d[acc_idx][8*k +: 8] = acc_wdata[8*k +: 8];
          end
        end
      end else begin
        readdata_d = mem_q[acc_idx];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      readdata_q <= '0;
      error_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      readdata_q <= readdata_d;
      error_q    <= error_d;
    end
  end

  // Memory array, cleared by reset
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH_BLOCKS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH_BLOCKS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_block_ctrl.sv
// Testbench for data_memory_block_ctrl: two instances (default parameters,
// and LATENCY=1 / BLOCK_BYTES=4) share clock and reset. Stimulus pushes the
// expected outcome of each request into a per-instance queue; a monitor per
// instance pops and compares when BUSYWAIT falls or ERROR pulses.
module tb_data_memory_block_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           kind;  // 0 write, 1 read, 2 error
    int           len;   // expected BUSYWAIT cycles
    logic [127:0] data;  // expected READDATA
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: defaults
  logic         a_read = 0, a_write = 0;
  logic [27:0]  a_addr = '0;
  logic [127:0] a_wd = '0;
  logic [15:0]  a_be = '0;
  logic [127:0] a_rd;
  logic         a_busy, a_err;

  data_memory_block_ctrl #(
    .ADDR_W(28), .BLOCK_BYTES(16), .DEPTH_BLOCKS(16), .LATENCY(5)
  ) dut_a (
    .CLOCK(clk), .RESET(rst_n), .READ(a_read), .WRITE(a_write),
    .ADDRESS(a_addr), .WRITEDATA(a_wd), .BYTE_EN(a_be),
    .READDATA(a_rd), .BUSYWAIT(a_busy), .ERROR(a_err)
  );

  // Instance B: single-cycle latency, 4-byte blocks
  logic         b_read = 0, b_write = 0;
  logic [27:0]  b_addr = '0;
  logic [31:0]  b_wd = '0;
  logic [3:0]   b_be = '0;
  logic [31:0]  b_rd;
  logic         b_busy, b_err;

  data_memory_block_ctrl #(
    .ADDR_W(28), .BLOCK_BYTES(4), .DEPTH_BLOCKS(16), .LATENCY(1)
  ) dut_b (
    .CLOCK(clk), .RESET(rst_n), .READ(b_read), .WRITE(b_write),
    .ADDRESS(b_addr), .WRITEDATA(b_wd), .BYTE_EN(b_be),
    .READDATA(b_rd), .BUSYWAIT(b_busy), .ERROR(b_err)
  );

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input int kind, input int len, input logic [127:0] data);
    exp_t e;
    e.kind = kind;
    e.len  = len;
    e.data = data;
    return e;
  endfunction

  // Monitor A
  int a_cnt = 0;
  bit a_prev = 0, a_eprev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      a_cnt = 0; a_prev = 0; a_eprev = 0;
    end else begin
      if (a_busy) a_cnt++;
      if (a_prev && !a_busy) begin
        if (qa.size() == 0) chk(0, "a_unexpected_done", 128'(a_cnt), 0);
        else begin
          e = qa.pop_front();
          chk(e.kind != 2 && a_cnt == e.len, "a_busy_len", 128'(a_cnt), 128'(e.len));
          if (e.kind == 1) chk(a_rd == e.data, "a_readdata", a_rd, e.data);
        end
        a_cnt = 0;
      end
      if (a_err) begin
        if (qa.size() == 0) chk(0, "a_unexpected_error", 1, 0);
        else begin
          e = qa.pop_front();
          chk(e.kind == 2 && !a_eprev && a_cnt == 0 && a_rd == e.data,
              "a_error_pulse", a_rd, e.data);
        end
      end
      a_prev = a_busy; a_eprev = a_err;
    end
  end

  // Monitor B
  int b_cnt = 0;
  bit b_prev = 0, b_eprev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      b_cnt = 0; b_prev = 0; b_eprev = 0;
    end else begin
      if (b_busy) b_cnt++;
      if (b_prev && !b_busy) begin
        if (qb.size() == 0) chk(0, "b_unexpected_done", 128'(b_cnt), 0);
        else begin
          e = qb.pop_front();
          chk(e.kind != 2 && b_cnt == e.len, "b_busy_len", 128'(b_cnt), 128'(e.len));
          if (e.kind == 1) chk({96'b0, b_rd} == e.data, "b_readdata", {96'b0, b_rd}, e.data);
        end
        b_cnt = 0;
      end
      if (b_err) begin
        if (qb.size() == 0) chk(0, "b_unexpected_error", 1, 0);
        else begin
          e = qb.pop_front();
          chk(e.kind == 2 && !b_eprev && b_cnt == 0 && {96'b0, b_rd} == e.data,
              "b_error_pulse", {96'b0, b_rd}, e.data);
        end
      end
      b_prev = b_busy; b_eprev = b_err;
    end
  end

  // Issue one request on A (called just after a rising edge) and wait for
  // BUSYWAIT to drop, then release the request and idle one cycle.
  task automatic req_a(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd, input logic [15:0] be);
    int n = 0;
    a_read = rd; a_write = wr; a_addr = addr; a_wd = wd; a_be = be;
    do begin
      @(posedge clk); #1;
      n++;
    end while (a_busy && n < 50);
    if (n >= 50) chk(0, "a_timeout", 128'(n), 0);
    a_read = 0; a_write = 0;
    @(posedge clk); #1;
  endtask

  task automatic req_b(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    b_read = rd; b_write = wr; b_addr = addr; b_wd = wd; b_be = be;
    do begin
      @(posedge clk); #1;
      n++;
    end while (b_busy && n < 50);
    if (n >= 50) chk(0, "b_timeout", 128'(n), 0);
    b_read = 0; b_write = 0;
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] W_FULL = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W_PART = 128'h00112233_44556677_8899AABB_CCDDEE5A;

  initial begin
    #12;
    chk(a_rd == '0, "reset_readdata", a_rd, 0);
    chk(a_err == 1'b0, "reset_error", 128'(a_err), 0);
    chk(a_busy == 1'b0, "reset_busy", 128'(a_busy), 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Instance A
    qa.push_back(mk(1, 5, 128'h0));
    req_a(1, 0, 28'd3, '0, '0);
    qa.push_back(mk(1, 5, 128'h0));
    req_a(1, 0, 28'd15, '0, '0);
    qa.push_back(mk(0, 5, 128'h0));
    req_a(0, 1, 28'd2, W_FULL, 16'hFFFF);
    qa.push_back(mk(1, 5, W_FULL));
    req_a(1, 0, 28'd2, '0, '0);
    qa.push_back(mk(0, 5, 128'h0));
    req_a(0, 1, 28'd2, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A55A, 16'h0001);
    qa.push_back(mk(1, 5, W_PART));
    req_a(1, 0, 28'd2, '0, '0);
    qa.push_back(mk(2, 0, W_PART));
    req_a(1, 1, 28'd1, {4{32'hFFFFFFFF}}, 16'hFFFF);
    qa.push_back(mk(2, 0, W_PART));
    req_a(1, 0, 28'd16, '0, '0);
    qa.push_back(mk(2, 0, W_PART));
    req_a(0, 1, 28'h8000002, {4{32'h12345678}}, 16'hFFFF);
    qa.push_back(mk(1, 5, 128'h0));
    req_a(1, 0, 28'd1, '0, '0);
    qa.push_back(mk(1, 5, W_PART));
    req_a(1, 0, 28'd2, '0, '0);

    // Write aborted by reset in the third ACCESS cycle
    a_write = 1; a_addr = 28'd4; a_wd = {4{32'hDEADBEEF}}; a_be = 16'hFFFF;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1 chk(a_busy == 1'b0, "a_busy_abort", 128'(a_busy), 0);
    a_write = 0;
    @(posedge clk); #1;
    chk(a_rd == '0, "a_readdata_abort", a_rd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa.push_back(mk(1, 5, 128'h0));
    req_a(1, 0, 28'd4, '0, '0);
    qa.push_back(mk(1, 5, 128'h0));
    req_a(1, 0, 28'd2, '0, '0);

    // Instance B
    qb.push_back(mk(1, 1, 128'h0));
    req_b(1, 0, 28'd3, '0, '0);
    qb.push_back(mk(0, 1, 128'h0));
    req_b(0, 1, 28'd2, 32'hCCDDEEFF, 4'hF);
    qb.push_back(mk(1, 1, 128'hCCDDEEFF));
    req_b(1, 0, 28'd2, '0, '0);
    qb.push_back(mk(0, 1, 128'h0));
    req_b(0, 1, 28'd2, 32'h11117711, 4'h2);
    qb.push_back(mk(1, 1, 128'hCCDD77FF));
    req_b(1, 0, 28'd2, '0, '0);
    qb.push_back(mk(2, 0, 128'hCCDD77FF));
    req_b(1, 0, 28'd16, '0, '0);
    qb.push_back(mk(1, 1, 128'h0));
    req_b(1, 0, 28'd15, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk(qa.size() == 0, "a_queue_drained", 128'(qa.size()), 0);
    chk(qb.size() == 0, "b_queue_drained", 128'(qb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_block_ctrl.md
Name: data_memory_block_ctrl

Overview:
Parametrised block-organised data memory for the cache miss path, below the data cache. Serves one block read or one byte-enabled block write per request, with a programmable cycle latency. Signals a BUSYWAIT handshake to the cache and raises ERROR on illegal requests. Replaces the fixed 16-byte, delay-based memory with synthesizable cycle-counted timing.

Parameters:
ADDR_W, 28, width of the block address input (byte address bits above the block offset)
BLOCK_BYTES, 16, bytes per block; power of 2, minimum 4
DEPTH_BLOCKS, 16, number of implemented blocks; power of 2, at most 2^ADDR_W
LATENCY, 5, cycles BUSYWAIT stays high per accepted access; minimum 1

Ports:
CLOCK  in  1  system clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-low reset
READ  in  1  block read request
WRITE  in  1  block write request
ADDRESS  in  ADDR_W  block address
WRITEDATA  in  8*BLOCK_BYTES  write block; byte k is bits [8k+7:8k]
BYTE_EN  in  BLOCK_BYTES  per-byte write enable; ignored on reads
READDATA  out  8*BLOCK_BYTES  read block, registered
BUSYWAIT  out  1  access in progress; requester holds its inputs while high
ERROR  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE; latency counter 0; READDATA 0; ERROR 0.
  - all DEPTH_BLOCKS*BLOCK_BYTES memory bytes cleared to 0.
  - An access in flight is aborted and no write is committed.
- Valid request:
  - READ xor WRITE, sampled in IDLE.
  - ADDRESS must be below DEPTH_BLOCKS, compared on the full ADDR_W bits. There is no wrap-around.
- State machine (IDLE, ACCESS, DONE):
  - IDLE with a valid request, at a rising edge: latch ADDRESS, op, WRITEDATA and BYTE_EN; load the counter with LATENCY-1; go to ACCESS. If LATENCY=1, go straight to DONE and perform the access on that edge.
  - IDLE with READ=WRITE=1, or ADDRESS out of range: pulse ERROR for the next cycle, stay IDLE, leave memory and READDATA untouched.
  - IDLE with no request: stay IDLE.
  - ACCESS: decrement the counter each edge. When the counter is 1, the next edge performs the access and moves to DONE.
    - Read: READDATA <= latched block.
    - Write: update only the bytes with BYTE_EN[k]=1.
  - DONE: lasts one cycle and always returns to IDLE. Requests are not sampled in DONE.
- BUSYWAIT (combinational):
  - high when state is ACCESS, or when state is IDLE with a valid request present.
  - low in DONE.
  - So BUSYWAIT is high for exactly LATENCY cycles, starting in the request cycle.
- Requester obligations:
  - Deassert READ/WRITE during the DONE cycle, or the request is re-issued from IDLE on the following cycle.
  - Input changes during ACCESS are ignored because the latched copies are used.
- Read-after-write to the same block, issued back-to-back, returns the newly written data.
- READDATA holds its value between reads and across writes and errors.
- Addressing: byte index = {latched ADDRESS[log2(DEPTH_BLOCKS)-1:0], offset}. Upper address bits are used only for the range check.

Test Plan:
- Reset, then READ at ADDRESS=3 with LATENCY=5 -> BUSYWAIT high for 5 cycles; READDATA=0; ERROR stays 0.
- WRITE at ADDRESS=2 with WRITEDATA=0x00112233_44556677_8899AABB_CCDDEEFF and BYTE_EN=0xFFFF, then READ at ADDRESS=2 -> READDATA equals the same value.
- WRITE at ADDRESS=2 with BYTE_EN=0x0001 and WRITEDATA low byte 0x5A -> a subsequent read returns 0x...CCDDEE5A; the other 15 bytes are unchanged.
- READ=WRITE=1 at ADDRESS=1, and separately READ at ADDRESS=16 with DEPTH_BLOCKS=16 -> each produces a one-cycle ERROR pulse; BUSYWAIT never rises; memory and READDATA are unchanged.
- WRITE at ADDRESS=4, then drive RESET=0 in the third ACCESS cycle -> BUSYWAIT drops immediately; a read at ADDRESS=4 after reset returns 0.
- Re-run the first two scenarios with LATENCY=1 and BLOCK_BYTES=4 -> BUSYWAIT is high for 1 cycle and the data round-trips correctly.
